// File: rtl/sub_resp_pipe_if.sv
// Operand/result handshake bundle for sub_resp_pipe.
// The slave modport is the pipe itself; the master modport is the driver/consumer side.
interface sub_resp_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in1, in2, in_valid, out_ready,
        output in_ready, out, borrow, out_valid
    );

    modport master (
        output in1, in2, in_valid, out_ready,
        input  in_ready, out, borrow, out_valid
    );
endinterface

// File: rtl/sub_resp_pipe.sv
// Two-stage valid/ready subtractor (in1 - in2) with borrow flag and completed-handshake counter.
// Build macro SUB_SAT_EN: when defined, underflowing results clamp to zero instead of wrapping.
module sub_resp_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    sub_resp_pipe_if.slave   bus,
    output logic [CNT_W-1:0] txn_cnt
);
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             borrow_q, borrow_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   diff;
    logic             stall;

    assign stall = out_valid_q && !bus.out_ready;
    // Zero-extended subtraction: the top bit is set exactly when s1_a < s1_b.
    assign diff  = {1'b0, s1_a_q} - {1'b0, s1_b_q};

    always_comb begin
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_valid_d  = s1_valid_q;
        out_d       = out_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (!stall) begin
            s1_a_d      = bus.in1;
            s1_b_d      = bus.in2;
            s1_valid_d  = bus.in_valid;
            borrow_d    = diff[WIDTH];
            out_valid_d = s1_valid_q;
`ifdef SUB_SAT_EN
            out_d       = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
            out_d       = diff[WIDTH-1:0];
`endif
        end

        if (out_valid_q && bus.out_ready) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_valid_q  <= s1_valid_d;
            out_q       <= out_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // in_ready is combinational on out_ready so a draining consumer frees the pipe the same cycle.
    assign bus.in_ready  = !stall;
    assign bus.out       = out_q;
    assign bus.borrow    = borrow_q;
    assign bus.out_valid = out_valid_q;
    assign txn_cnt       = cnt_q;
endmodule

// File: tb/tb_sub_resp_pipe.sv
// Directed testbench for sub_resp_pipe: reset, arithmetic, streaming, stall, mid-flight reset, counter wrap.
module tb_sub_resp_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] txn_cnt;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               exp_cnt = 0;

    // Stream vectors and hand-computed results.
    logic [7:0] va [8] = '{8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd120};
    logic [7:0] vb [8] = '{8'd10, 8'd70, 8'd5, 8'd100, 8'd0, 8'd99, 8'd200, 8'd1};
    logic       vbor [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SUB_SAT_EN
    logic [7:0] vexp [8] = '{8'd40, 8'd0, 8'd65, 8'd0, 8'd90, 8'd1, 8'd0, 8'd119};
    localparam logic [7:0] EXP_10_20 = 8'd0;
    localparam logic [7:0] EXP_0_255 = 8'd0;
`else
    logic [7:0] vexp [8] = '{8'd40, 8'd246, 8'd65, 8'd236, 8'd90, 8'd1, 8'd166, 8'd119};
    localparam logic [7:0] EXP_10_20 = 8'd246;
    localparam logic [7:0] EXP_0_255 = 8'd1;
`endif

    sub_resp_pipe_if #(.WIDTH(WIDTH)) bus ();

    sub_resp_pipe #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .txn_cnt (txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in1 = '0; bus.in2 = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out !== 8'd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", bus.out); end
        n_tests++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b want 0", bus.borrow); end
        n_tests++; if (txn_cnt !== '0) begin n_fail++; $display("FAIL reset_txn_cnt got %0d want 0", txn_cnt); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        rst = 1'b0;
        tick();
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
        $display("[TB] reset done");
    endtask

    task automatic test_single();
        bus.in1 = 8'd200; bus.in2 = 8'd55; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", bus.out_valid); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        n_tests++; if (bus.out !== 8'd145) begin n_fail++; $display("FAIL single_out got %0d want 145", bus.out); end
        n_tests++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL single_borrow got %b want 0", bus.borrow); end
        tick();
        exp_cnt += 1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_dup got %b want 0", bus.out_valid); end
        n_tests++; if (txn_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL single_txn_cnt got %0d want %0d", txn_cnt, exp_cnt); end
        $display("[TB] single 200-55 -> out=%0d borrow=%b", bus.out, bus.borrow);
    endtask

    task automatic test_arith();
        logic [7:0] ta [4] = '{8'd10, 8'd77, 8'd0, 8'd255};
        logic [7:0] tb [4] = '{8'd20, 8'd77, 8'd255, 8'd0};
        logic [7:0] te [4];
        logic       tbr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        te[0] = EXP_10_20; te[1] = 8'd0; te[2] = EXP_0_255; te[3] = 8'd255;
        for (int i = 0; i < 4; i++) begin
            bus.in1 = ta[i]; bus.in2 = tb[i]; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            tick();
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arith%0d_valid got %b want 1", i, bus.out_valid); end
            n_tests++; if (bus.out !== te[i]) begin n_fail++; $display("FAIL arith%0d_out got %0d want %0d", i, bus.out, te[i]); end
            n_tests++; if (bus.borrow !== tbr[i]) begin n_fail++; $display("FAIL arith%0d_borrow got %b want %b", i, bus.borrow, tbr[i]); end
            $display("[TB] arith %0d-%0d -> out=%0d borrow=%b", ta[i], tb[i], bus.out, bus.borrow);
            tick();
            exp_cnt += 1;
        end
        n_tests++; if (txn_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL arith_txn_cnt got %0d want %0d", txn_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            bus.in_valid = (c < 8);
            if (c < 8) begin bus.in1 = va[c]; bus.in2 = vb[c]; end
            #1;
            n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c%0d got %b want 1", c, bus.in_ready); end
            n_tests++; if (bus.out_valid !== ((c >= 2) && (c <= 9))) begin n_fail++; $display("FAIL b2b_valid c%0d got %b", c, bus.out_valid); end
            if (c >= 2 && c <= 9) begin
                n_tests++;
                if (bus.out !== vexp[c-2] || bus.borrow !== vbor[c-2]) begin
                    n_fail++; $display("FAIL b2b_data c%0d got %0d/%b want %0d/%b", c, bus.out, bus.borrow, vexp[c-2], vbor[c-2]);
                end
                $display("[TB] b2b out[%0d]=%0d borrow=%b", c-2, bus.out, bus.borrow);
            end
            tick();
        end
        exp_cnt += 8;
        n_tests++; if (txn_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL b2b_txn_cnt got %0d want %0d", txn_cnt, exp_cnt); end
    endtask

    task automatic test_stall();
        int  p = 0;
        int  k = 0;
        int  c = 0;
        int  last = -1;
        logic acc;
        while (k < 8 && c < 40) begin
            bus.out_ready = !(c >= 4 && c <= 6);
            bus.in_valid  = (p < 8);
            if (p < 8) begin bus.in1 = va[p]; bus.in2 = vb[p]; end
            #1;
            n_tests++;
            if (bus.in_ready !== !(c >= 4 && c <= 6)) begin
                n_fail++; $display("FAIL stall_in_ready c%0d got %b", c, bus.in_ready);
            end
            if (bus.out_valid) begin
                n_tests++;
                if (bus.out !== vexp[k] || bus.borrow !== vbor[k]) begin
                    n_fail++; $display("FAIL stall_data c%0d got %0d/%b want %0d/%b", c, bus.out, bus.borrow, vexp[k], vbor[k]);
                end
                if (bus.out_ready) begin
                    $display("[TB] stall out[%0d]=%0d at cycle %0d", k, bus.out, c);
                    k++;
                    last = c;
                end
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) p++;
            c++;
        end
        n_tests++; if (k !== 8) begin n_fail++; $display("FAIL stall_count got %0d want 8", k); end
        n_tests++; if (last !== 12) begin n_fail++; $display("FAIL stall_last_cycle got %0d want 12", last); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup %0d got %b want 0", i, bus.out_valid); end
            tick();
        end
        exp_cnt += 8;
        n_tests++; if (txn_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL stall_txn_cnt got %0d want %0d", txn_cnt, exp_cnt); end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        bus.in1 = 8'd9; bus.in2 = 8'd4; bus.in_valid = 1'b1;
        tick();
        bus.in1 = 8'd3; bus.in2 = 8'd8;
        tick();
        bus.in_valid = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %b want 1", bus.out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out !== 8'd0) begin n_fail++; $display("FAIL midrst_out got %0d want 0", bus.out); end
        n_tests++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL midrst_borrow got %b want 0", bus.borrow); end
        n_tests++; if (txn_cnt !== '0) begin n_fail++; $display("FAIL midrst_txn_cnt got %0d want 0", txn_cnt); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale %0d got %b want 0", i, bus.out_valid); end
        end
        n_tests++; if (txn_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt_after got %0d want 0", txn_cnt); end
        $display("[TB] mid-flight reset done");
    endtask

    task automatic test_wrap();
        bus.in1 = 8'd5; bus.in2 = 8'd3; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        repeat (CNT_MAX) tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_tests++; if (txn_cnt !== CNT_W'(CNT_MAX)) begin n_fail++; $display("FAIL wrap_max got %0d want %0d", txn_cnt, CNT_MAX); end
        $display("[TB] wrap preload txn_cnt=%0d", txn_cnt);
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            tick();
            tick();
            n_tests++; if (txn_cnt !== CNT_W'(i)) begin n_fail++; $display("FAIL wrap_step%0d got %0d want %0d", i, txn_cnt, i); end
            $display("[TB] wrap step %0d txn_cnt=%0d", i, txn_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in1 = '0; bus.in2 = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_arith();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
